// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
//   Load/store sequencer between the EX/MEM pipeline register and a word-wide
//   data memory with a 1-cycle registered read. Decodes the RV32 load/store
//   width (funct3), checks alignment and range, sign/zero-extends loads and
//   performs read-modify-write for SB/SH. Raises lsu_stall while an op is in
//   flight.
//
//   Handshake: a request is offered by holding req_valid=1 with stable req_*.
//   In IDLE the request is accepted in the same cycle. Exceptions and aligned
//   SW finish in that cycle (done=1). Loads and sub-word stores raise
//   lsu_stall for that cycle and finish one cycle later. done=1 marks the edge
//   at which the pipeline advances. While busy, req_* are ignored.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid       memory op present in EX/MEM this cycle
//   req_we          1 = store, 0 = load
//   req_funct3      000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr        byte address
//   req_wdata       store data
//   mem_re/mem_we   memory read / word-write enables (never both)
//   mem_addr        word index
//   mem_wdata       word to write
//   mem_rdata       read data, valid the cycle after mem_re
//   lsu_stall       hold the front of the pipeline this cycle
//   done            op completes this cycle
//   load_data       extended load result (0 unless done on a load)
//   misalign        alignment / illegal-funct3 exception (with done)
//   acc_fault       out-of-range exception (with done)
//   dbg_state       current FSM state, for observation
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              lsu_stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              acc_fault,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW_RD  = 2'd2
    } state_t;

    localparam logic [2:0]  F3_B    = 3'b000;
    localparam logic [2:0]  F3_H    = 3'b001;
    localparam logic [2:0]  F3_W    = 3'b010;
    localparam logic [2:0]  F3_BU   = 3'b100;
    localparam logic [2:0]  F3_HU   = 3'b101;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t state, state_nxt;

    // Registered copies of the accepted request; later states use only these.
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [15:0]       wdata_q;   // only the low half is ever merged
    logic [ADDR_W-1:0] idx_q;

    logic              f3_ok;
    logic              align_bad;
    logic              bad_op;
    logic              range_bad;
    logic [ADDR_W-1:0] idx_in;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ext_data;
    logic [31:0]       merged;

    assign idx_in    = req_addr[ADDR_W+1:2];
    // Range is judged on the full word index, not the truncated memory index.
    assign range_bad = ({2'b00, req_addr[31:2]} >= DEPTH_W);
    assign dbg_state = state;

    // Width decode and alignment. BU/HU have no store encoding, so a store
    // with those funct3 values is treated as illegal.
    always_comb begin
        f3_ok     = 1'b0;
        align_bad = 1'b0;
        case (req_funct3)
            F3_B:  f3_ok = 1'b1;
            F3_H:  begin f3_ok = 1'b1;     align_bad = req_addr[0];    end
            F3_W:  begin f3_ok = 1'b1;     align_bad = |req_addr[1:0]; end
            F3_BU: f3_ok = !req_we;
            F3_HU: begin f3_ok = !req_we;  align_bad = req_addr[0];    end
            default: f3_ok = 1'b0;
        endcase
        bad_op = !f3_ok || align_bad;
    end

    // Lane selection, extension and sub-word merge on the returned word.
    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            F3_B:    ext_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   ext_data = {24'd0, rd_byte};
            F3_H:    ext_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   ext_data = {16'd0, rd_half};
            F3_W:    ext_data = mem_rdata;
            default: ext_data = 32'd0;
        endcase
        merged = mem_rdata;
        if (f3_q == F3_B) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            wdata_q <= 16'd0;
            idx_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                wdata_q <= req_wdata[15:0];
                idx_q   <= idx_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        lsu_stall = 1'b0;
        done      = 1'b0;
        load_data = 32'd0;
        misalign  = 1'b0;
        acc_fault = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (bad_op) begin
                        // Misalign takes priority over an out-of-range address.
                        misalign = 1'b1;
                        done     = 1'b1;
                    end else if (range_bad) begin
                        acc_fault = 1'b1;
                        done      = 1'b1;
                    end else if (req_we && req_funct3 == F3_W) begin
                        mem_we    = 1'b1;
                        mem_addr  = idx_in;
                        mem_wdata = req_wdata;
                        done      = 1'b1;
                    end else begin
                        // Loads and SB/SH both need the current word first.
                        mem_re    = 1'b1;
                        mem_addr  = idx_in;
                        lsu_stall = 1'b1;
                        state_nxt = req_we ? RMW_RD : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                mem_addr  = idx_q;
                load_data = ext_data;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            RMW_RD: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = merged;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Reset silences every output in the same cycle so a half-finished
        // read-modify-write can never reach memory.
        if (rst) begin
            state_nxt = IDLE;
            mem_re    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 32'd0;
            lsu_stall = 1'b0;
            done      = 1'b0;
            load_data = 32'd0;
            misalign  = 1'b0;
            acc_fault = 1'b0;
        end
    end

endmodule
